// File: rtl/dram_cmd_pkg.sv
// Shared types for the DRAM command path: arbiter state encoding and the
// strobe group that marks a cycle as carrying a command.
package dram_cmd_pkg;

   typedef enum logic [1:0] {
      ST_NORMAL  = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_REFRESH = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic cas;
      logic ras;
      logic we;
   } cmd_strb_t;

   // A cycle carries a command when any strobe is asserted.
   function automatic logic any_strobe(cmd_strb_t s);
      return s.cas | s.ras | s.we;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin request picker: finds the first asserted request at or after
// ptr_i, wrapping modulo NBANKS. Purely combinational.
module rr_picker #(
   parameter int NBANKS = 8,
   localparam int PW    = $clog2(NBANKS)
) (
   input  logic [NBANKS-1:0] req_i,
   input  logic [PW-1:0]     ptr_i,
   output logic              found_o,
   output logic [PW-1:0]     idx_o
);

   logic [PW:0] k;

   // Walk the rotated request vector from the far end back toward ptr_i so the
   // closest request after the pointer is the one left standing.
   always_comb begin
      // NOTE: every variable written here gets a default first so no path can infer a latch.
      found_o = 1'b0;
      idx_o   = '0;
      k       = '0;
      for (int j = NBANKS - 1; j >= 0; j--) begin
         k = {1'b0, ptr_i} + (PW + 1)'(j);
         if (k >= (PW + 1)'(NBANKS)) begin
            k = k - (PW + 1)'(NBANKS);
         end
         if (req_i[k[PW-1:0]]) begin
            found_o = 1'b1;
            idx_o   = k[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/refresh_cmd_arbiter.sv
// Shares the single DRAM command slot between the refresher and NBANKS bank
// machines. Banks are granted round-robin; a pending refresh blocks new bank
// grants, drains the output register, then owns the slot until ref_cmd_last.
module refresh_cmd_arbiter
   import dram_cmd_pkg::*;
#(
   parameter int NBANKS = 8,
   parameter int ABITS  = 17,
   parameter int BABITS = 3
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     ref_cmd_valid,
   output logic                     ref_cmd_ready,
   input  logic                     ref_cmd_last,
   input  logic [ABITS-1:0]         ref_cmd_a,
   input  logic [BABITS-1:0]        ref_cmd_ba,
   input  logic                     ref_cmd_cas,
   input  logic                     ref_cmd_ras,
   input  logic                     ref_cmd_we,
   input  logic [NBANKS-1:0]        bm_valid,
   output logic [NBANKS-1:0]        bm_ready,
   input  logic [NBANKS*ABITS-1:0]  bm_a,
   input  logic [NBANKS*BABITS-1:0] bm_ba,
   input  logic [NBANKS-1:0]        bm_cas,
   input  logic [NBANKS-1:0]        bm_ras,
   input  logic [NBANKS-1:0]        bm_we,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ABITS-1:0]         out_a,
   output logic [BABITS-1:0]        out_ba,
   output logic                     out_cas,
   output logic                     out_ras,
   output logic                     out_we,
   output logic                     refresh_active
);

   localparam int PW = $clog2(NBANKS);

   typedef struct packed {
      logic [ABITS-1:0]  a;
      logic [BABITS-1:0] ba;
      cmd_strb_t         strb;
   } cmd_t;

   arb_state_e    state_q, state_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic          out_valid_q, out_valid_d;
   cmd_t          out_q, out_d;

   logic          out_free;
   logic          pick_found;
   logic [PW-1:0] pick_idx;
   cmd_t          bank_cmd;
   cmd_t          ref_cmd;

   assign out_free = ~out_valid_q | out_ready;

   rr_picker #(.NBANKS(NBANKS)) u_picker (
      .req_i   (bm_valid),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // Gather the refresher payload and the payload of the bank the picker chose.
   always_comb begin
      ref_cmd.a         = ref_cmd_a;
      ref_cmd.ba        = ref_cmd_ba;
      ref_cmd.strb.cas  = ref_cmd_cas;
      ref_cmd.strb.ras  = ref_cmd_ras;
      ref_cmd.strb.we   = ref_cmd_we;
      bank_cmd.a        = bm_a[int'(pick_idx)*ABITS +: ABITS];
      bank_cmd.ba       = bm_ba[int'(pick_idx)*BABITS +: BABITS];
      bank_cmd.strb.cas = bm_cas[pick_idx];
      bank_cmd.strb.ras = bm_ras[pick_idx];
      bank_cmd.strb.we  = bm_we[pick_idx];
   end

   // Next-state, grant and output-register load decisions.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      out_valid_d   = out_valid_q;
      out_d         = out_q;
      bm_ready      = '0;
      ref_cmd_ready = 1'b0;

      // An accepted command leaves the register unless something replaces it.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         ST_NORMAL: begin
            if (ref_cmd_valid) begin
               state_d = ST_DRAIN;
            end else if (pick_found && out_free) begin
               bm_ready[pick_idx] = 1'b1;
               out_d              = bank_cmd;
               out_valid_d        = 1'b1;
               rr_ptr_d           = (int'(pick_idx) == NBANKS - 1) ? '0 : pick_idx + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (!ref_cmd_valid) begin
               state_d = ST_NORMAL;
            end else if (out_free) begin
               state_d = ST_REFRESH;
            end
         end
         ST_REFRESH: begin
            // The refresher never stalls, so its commands load regardless of out_ready.
            ref_cmd_ready = 1'b1;
            if (any_strobe(ref_cmd.strb)) begin
               out_d       = ref_cmd;
               out_valid_d = 1'b1;
            end
            if (ref_cmd_last) begin
               state_d = ST_NORMAL;
            end
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   // State, round-robin pointer and output register.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= ST_NORMAL;
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_a          = out_q.a;
   assign out_ba         = out_q.ba;
   assign out_cas        = out_q.strb.cas;
   assign out_ras        = out_q.strb.ras;
   assign out_we         = out_q.strb.we;
   assign refresh_active = (state_q != ST_NORMAL);

endmodule

// File: tb/tb_refresh_cmd_arbiter.sv
// Self-checking bench for refresh_cmd_arbiter: a table of directed cycles,
// hand-written multi-cycle sequences, and randomized traffic compared against
// a behavioural model of the slot-sharing rules.
module tb_refresh_cmd_arbiter;

   localparam int NB = 8;
   localparam int AB = 17;
   localparam int BB = 3;

   logic             sys_clk = 1'b0;
   logic             sys_rst;
   logic             ref_cmd_valid, ref_cmd_ready, ref_cmd_last;
   logic [AB-1:0]    ref_cmd_a;
   logic [BB-1:0]    ref_cmd_ba;
   logic             ref_cmd_cas, ref_cmd_ras, ref_cmd_we;
   logic [NB-1:0]    bm_valid, bm_ready;
   logic [NB*AB-1:0] bm_a;
   logic [NB*BB-1:0] bm_ba;
   logic [NB-1:0]    bm_cas, bm_ras, bm_we;
   logic             out_valid, out_ready;
   logic [AB-1:0]    out_a;
   logic [BB-1:0]    out_ba;
   logic             out_cas, out_ras, out_we;
   logic             refresh_active;

   int n_checks = 0;
   int n_fail   = 0;

   refresh_cmd_arbiter #(.NBANKS(NB), .ABITS(AB), .BABITS(BB)) dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .ref_cmd_valid  (ref_cmd_valid),
      .ref_cmd_ready  (ref_cmd_ready),
      .ref_cmd_last   (ref_cmd_last),
      .ref_cmd_a      (ref_cmd_a),
      .ref_cmd_ba     (ref_cmd_ba),
      .ref_cmd_cas    (ref_cmd_cas),
      .ref_cmd_ras    (ref_cmd_ras),
      .ref_cmd_we     (ref_cmd_we),
      .bm_valid       (bm_valid),
      .bm_ready       (bm_ready),
      .bm_a           (bm_a),
      .bm_ba          (bm_ba),
      .bm_cas         (bm_cas),
      .bm_ras         (bm_ras),
      .bm_we          (bm_we),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_a          (out_a),
      .out_ba         (out_ba),
      .out_cas        (out_cas),
      .out_ras        (out_ras),
      .out_we         (out_we),
      .refresh_active (refresh_active)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Fixed bank payloads for the directed phases.
   function automatic logic [AB-1:0] bank_a(int i);
      return AB'(i * 257 + 5);
   endfunction

   task automatic set_fixed_payload();
      for (int i = 0; i < NB; i++) begin
         bm_a[i*AB +: AB] = bank_a(i);
         bm_ba[i*BB +: BB] = BB'(i) ^ 3'b101;
         bm_cas[i] = (i & 1) != 0;
         bm_ras[i] = (i & 2) != 0;
         bm_we[i]  = (i & 4) != 0;
      end
   endtask

   task automatic drive(input logic rv, input logic rl, input logic [2:0] strb,
                        input logic [AB-1:0] ra, input logic [NB-1:0] bv, input logic rdy);
      ref_cmd_valid = rv;
      ref_cmd_last  = rl;
      {ref_cmd_cas, ref_cmd_ras, ref_cmd_we} = strb;
      ref_cmd_a     = ra;
      ref_cmd_ba    = '0;
      bm_valid      = bv;
      out_ready     = rdy;
   endtask

   // Check one cycle just after the inputs settle, then advance to the next drive point.
   task automatic expect_cycle(input string nm, input logic [NB-1:0] e_bm, input logic e_rr,
                               input logic e_ov, input logic e_act, input logic [AB-1:0] e_a,
                               input logic [2:0] e_s);
      #1;
      check({nm, " bm_ready"}, 64'(bm_ready), 64'(e_bm));
      check({nm, " ref_cmd_ready"}, 64'(ref_cmd_ready), 64'(e_rr));
      check({nm, " out_valid"}, 64'(out_valid), 64'(e_ov));
      check({nm, " refresh_active"}, 64'(refresh_active), 64'(e_act));
      if (e_ov) begin
         check({nm, " out_a"}, 64'(out_a), 64'(e_a));
         check({nm, " out_strobes"}, 64'({out_cas, out_ras, out_we}), 64'(e_s));
      end
      @(negedge sys_clk);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      drive(0, 0, 3'b000, '0, '0, 1'b1);
      @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   typedef struct packed {
      logic          rv;
      logic          rl;
      logic [2:0]    strb;
      logic [AB-1:0] ra;
      logic [NB-1:0] bv;
      logic          rdy;
      logic [NB-1:0] e_bm;
      logic          e_rr;
      logic          e_ov;
      logic          e_act;
      logic [AB-1:0] e_a;
      logic [2:0]    e_s;
   } vec_t;

   vec_t tbl[15];

   // Behavioural model: who owns the slot, and what the output register holds.
   bit            m_want;   // refresh requested, waiting for the slot to empty
   bit            m_own;    // refresher owns the slot
   int            m_next;   // first bank to consider on the next search
   bit            m_ov;
   logic [AB-1:0] m_a;
   logic [BB-1:0] m_ba;
   logic [2:0]    m_s;

   task automatic model_reset();
      m_want = 0; m_own = 0; m_next = 0; m_ov = 0; m_a = '0; m_ba = '0; m_s = '0;
   endtask

   initial begin
      logic [NB-1:0] prev_bv, prev_grant, exp_grant;
      bit            drop_next;
      int            gi;
      bit            free, accepted;
      logic [33:0]   act_v, exp_v;

      set_fixed_payload();
      sys_rst = 1'b1;
      drive(0, 0, 3'b000, '0, '0, 1'b1);
      @(negedge sys_clk);
      @(negedge sys_clk);
      #1;
      check("reset out_valid", 64'(out_valid), 64'(0));
      check("reset ref_cmd_ready", 64'(ref_cmd_ready), 64'(0));
      check("reset bm_ready", 64'(bm_ready), 64'(0));
      check("reset refresh_active", 64'(refresh_active), 64'(0));
      check("reset out_payload", 64'({out_a, out_ba, out_cas, out_ras, out_we}), 64'(0));
      @(negedge sys_clk);
      sys_rst = 1'b0;

      // ---- table: round-robin, full load, refresh colliding with a bank request
      //            rv rl strb    ra       bv     rdy  e_bm   rr ov act e_a     e_s
      tbl[0]  = '{1'b0, 1'b0, 3'b000, 17'd0,    8'h24, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 17'd0,    3'b000};
      tbl[1]  = '{1'b0, 1'b0, 3'b000, 17'd0,    8'h20, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 17'd519,  3'b010};
      tbl[2]  = '{1'b0, 1'b0, 3'b000, 17'd0,    8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 17'd1290, 3'b101};
      tbl[3]  = '{1'b0, 1'b0, 3'b000, 17'd0,    8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 17'd0,    3'b000};
      tbl[4]  = '{1'b0, 1'b0, 3'b000, 17'd0,    8'hFF, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 17'd0,    3'b000};
      tbl[5]  = '{1'b0, 1'b0, 3'b000, 17'd0,    8'hFF, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 17'd1547, 3'b011};
      tbl[6]  = '{1'b0, 1'b0, 3'b000, 17'd0,    8'hFF, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 17'd1804, 3'b111};
      tbl[7]  = '{1'b0, 1'b0, 3'b000, 17'd0,    8'hFF, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 17'd5,    3'b000};
      tbl[8]  = '{1'b1, 1'b0, 3'b000, 17'd0,    8'h08, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 17'd262,  3'b100};
      tbl[9]  = '{1'b1, 1'b0, 3'b000, 17'd0,    8'h08, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 17'd0,    3'b000};
      tbl[10] = '{1'b1, 1'b0, 3'b011, 17'd1024, 8'h08, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 17'd0,    3'b000};
      tbl[11] = '{1'b1, 1'b0, 3'b110, 17'd0,    8'h08, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 17'd1024, 3'b011};
      tbl[12] = '{1'b1, 1'b1, 3'b000, 17'd0,    8'h08, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 17'd0,    3'b110};
      tbl[13] = '{1'b0, 1'b0, 3'b000, 17'd0,    8'h08, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 17'd0,    3'b000};
      tbl[14] = '{1'b0, 1'b0, 3'b000, 17'd0,    8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 17'd776,  3'b110};
      for (int r = 0; r < 15; r++) begin
         drive(tbl[r].rv, tbl[r].rl, tbl[r].strb, tbl[r].ra, tbl[r].bv, tbl[r].rdy);
         expect_cycle($sformatf("tbl%0d", r), tbl[r].e_bm, tbl[r].e_rr, tbl[r].e_ov,
                      tbl[r].e_act, tbl[r].e_a, tbl[r].e_s);
      end

      // ---- PHY stall: output held, no grants, then resume
      do_reset();
      drive(0, 0, 3'b000, '0, 8'h02, 1); expect_cycle("stall grant1", 8'h02, 0, 0, 0, '0, 3'b000);
      for (int s = 0; s < 3; s++) begin
         drive(0, 0, 3'b000, '0, 8'h05, 0);
         expect_cycle($sformatf("stall hold%0d", s), 8'h00, 0, 1, 0, 17'd262, 3'b100);
      end
      drive(0, 0, 3'b000, '0, 8'h05, 1); expect_cycle("stall resume", 8'h04, 0, 1, 0, 17'd262, 3'b100);
      drive(0, 0, 3'b000, '0, 8'h01, 1); expect_cycle("stall next", 8'h01, 0, 1, 0, 17'd519, 3'b010);

      // ---- refresh with a stalled output: two DRAIN cycles, PRE + REF, then banks resume
      do_reset();
      drive(0, 0, 3'b000, '0, 8'h10, 1);        expect_cycle("drn grant4", 8'h10, 0, 0, 0, '0, 3'b000);
      drive(1, 0, 3'b000, '0, 8'h00, 0);        expect_cycle("drn req", 8'h00, 0, 1, 0, 17'd1033, 3'b001);
      drive(1, 0, 3'b000, '0, 8'h00, 0);        expect_cycle("drn hold1", 8'h00, 0, 1, 1, 17'd1033, 3'b001);
      drive(1, 0, 3'b000, '0, 8'h00, 1);        expect_cycle("drn hold2", 8'h00, 0, 1, 1, 17'd1033, 3'b001);
      drive(1, 0, 3'b011, 17'd1024, 8'h00, 1);  expect_cycle("ref pre", 8'h00, 1, 0, 1, '0, 3'b000);
      drive(1, 0, 3'b110, '0, 8'h00, 1);        expect_cycle("ref ref", 8'h00, 1, 1, 1, 17'd1024, 3'b011);
      drive(1, 1, 3'b000, '0, 8'h20, 1);        expect_cycle("ref last", 8'h00, 1, 1, 1, 17'd0, 3'b110);
      drive(0, 0, 3'b000, '0, 8'h20, 1);        expect_cycle("ref resume", 8'h20, 0, 0, 0, '0, 3'b000);

      // ---- asynchronous reset in the middle of a refresh
      do_reset();
      drive(0, 0, 3'b000, '0, 8'h40, 1);        expect_cycle("rst grant6", 8'h40, 0, 0, 0, '0, 3'b000);
      drive(1, 0, 3'b000, '0, 8'h00, 1);        expect_cycle("rst req", 8'h00, 0, 1, 0, 17'd1547, 3'b011);
      drive(1, 0, 3'b000, '0, 8'h00, 1);        expect_cycle("rst drain", 8'h00, 0, 0, 1, '0, 3'b000);
      drive(1, 0, 3'b110, '0, 8'h00, 1);        expect_cycle("rst refcmd", 8'h00, 1, 0, 1, '0, 3'b000);
      drive(1, 0, 3'b000, '0, 8'h81, 0);
      #2;
      check("rst pre out_valid", 64'(out_valid), 64'(1));
      sys_rst = 1'b1;
      #1;
      check("rst async out_valid", 64'(out_valid), 64'(0));
      check("rst async ref_cmd_ready", 64'(ref_cmd_ready), 64'(0));
      check("rst async refresh_active", 64'(refresh_active), 64'(0));
      @(negedge sys_clk);
      sys_rst = 1'b0;
      drive(0, 0, 3'b000, '0, 8'h81, 1);
      expect_cycle("rst ptr0 grant", 8'h01, 0, 0, 0, '0, 3'b000);

      // ---- randomized traffic against the behavioural model
      do_reset();
      model_reset();
      prev_bv    = '0;
      prev_grant = '0;
      drop_next  = 0;
      for (int c = 0; c < 2000; c++) begin
         bm_valid = (prev_bv & ~prev_grant) | (NB'($urandom) & NB'($urandom) & NB'($urandom));
         for (int i = 0; i < NB; i++) begin
            bm_a[i*AB +: AB]  = AB'($urandom);
            bm_ba[i*BB +: BB] = BB'($urandom);
         end
         bm_cas = NB'($urandom);
         bm_ras = NB'($urandom);
         bm_we  = NB'($urandom);

         ref_cmd_last = 1'b0;
         {ref_cmd_cas, ref_cmd_ras, ref_cmd_we} = 3'b000;
         ref_cmd_a  = '0;
         ref_cmd_ba = '0;
         if (drop_next) begin
            ref_cmd_valid = 1'b0;
            drop_next     = 0;
         end else if (m_own) begin
            ref_cmd_valid = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
               {ref_cmd_cas, ref_cmd_ras, ref_cmd_we} = 3'($urandom_range(1, 7));
               ref_cmd_a  = AB'($urandom);
               ref_cmd_ba = BB'($urandom);
            end
            if ($urandom_range(0, 5) == 0) begin
               ref_cmd_last = 1'b1;
               drop_next    = 1;
            end
         end else if (m_want) begin
            ref_cmd_valid = ($urandom_range(0, 9) != 0);
         end else begin
            ref_cmd_valid = ($urandom_range(0, 19) == 0);
         end
         out_ready = m_own ? 1'b1 : ($urandom_range(0, 9) < 7);

         // Expected grant: nearest requesting bank from m_next, only when banks may go.
         free      = !m_ov || out_ready;
         gi        = -1;
         exp_grant = '0;
         if (!m_own && !m_want && !ref_cmd_valid && free) begin
            for (int k = 0; k < NB; k++) begin
               if (gi < 0 && bm_valid[(m_next + k) % NB]) gi = (m_next + k) % NB;
            end
            if (gi >= 0) exp_grant[gi] = 1'b1;
         end

         #1;
         act_v = {bm_ready, ref_cmd_ready, out_valid, refresh_active,
                  out_valid ? {out_a, out_ba, out_cas, out_ras, out_we} : 23'd0};
         exp_v = {exp_grant, 1'(m_own), 1'(m_ov), 1'(m_want | m_own),
                  m_ov ? {m_a, m_ba, m_s} : 23'd0};
         check($sformatf("rand cycle %0d", c), 64'(act_v), 64'(exp_v));

         // Advance the model by one clock.
         accepted = m_ov && out_ready;
         if (m_own) begin
            if (ref_cmd_cas || ref_cmd_ras || ref_cmd_we) begin
               m_ov = 1; m_a = ref_cmd_a; m_ba = ref_cmd_ba;
               m_s = {ref_cmd_cas, ref_cmd_ras, ref_cmd_we};
            end else if (accepted) begin
               m_ov = 0;
            end
            if (ref_cmd_last) m_own = 0;
         end else if (m_want) begin
            if (accepted) m_ov = 0;
            if (!ref_cmd_valid) begin
               m_want = 0;
            end else if (free) begin
               m_want = 0;
               m_own  = 1;
            end
         end else begin
            if (ref_cmd_valid) m_want = 1;
            if (gi >= 0) begin
               m_ov   = 1;
               m_a    = bm_a[gi*AB +: AB];
               m_ba   = bm_ba[gi*BB +: BB];
               m_s    = {bm_cas[gi], bm_ras[gi], bm_we[gi]};
               m_next = (gi + 1) % NB;
            end else if (accepted) begin
               m_ov = 0;
            end
         end
         prev_bv    = bm_valid;
         prev_grant = exp_grant;
         @(negedge sys_clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
